// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that hands bytes from N_REQ requesters to a single UART
// transmitter, one frame at a time, with a watchdog on the frame-done handshake.
module uart_tx_arb #(
  parameter  int N_REQ       = 4,
  parameter  int TIMEOUT_CYC = 65535,
  localparam int GW          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic [GW-1:0]        grant_id,
  output logic                 arb_busy,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  localparam logic [GW-1:0] LAST_INIT = GW'(N_REQ - 1);
  localparam logic [15:0]   WD_LAST   = 16'(TIMEOUT_CYC - 1);

  state_t             r_state;
  state_t             w_next;
  logic [GW-1:0]      r_last_gnt;
  logic [GW-1:0]      r_grant_id;
  logic [7:0]         r_tx_data;
  logic               r_tx_start;
  logic [15:0]        r_wdog;

  logic               w_hi_found;
  logic               w_lo_found;
  logic [GW-1:0]      w_hi_idx;
  logic [GW-1:0]      w_lo_idx;
  logic               w_win_found;
  logic [GW-1:0]      w_win_idx;
  logic [N_REQ-1:0]   w_onehot;
  logic [7:0]         w_win_byte;
  logic               w_accept;
  logic               w_timeout;

  // Split the search into indices above last_gnt (searched first) and the
  // wrapped-around remainder; the lowest valid index in each half wins.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (i > int'(r_last_gnt)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = GW'(i);
        end else begin
          w_lo_found = 1'b1;
          w_lo_idx   = GW'(i);
        end
      end
    end
  end

  assign w_win_found = w_hi_found | w_lo_found;
  assign w_win_idx   = w_hi_found ? w_hi_idx : w_lo_idx;

  always_comb begin
    w_onehot   = '0;
    w_win_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win_found && (GW'(i) == w_win_idx)) begin
        w_onehot[i] = 1'b1;
        w_win_byte  = req_data[8*i +: 8];
      end
    end
  end

  assign w_accept  = (r_state == S_IDLE) && rst_n && !tx_busy && w_win_found;
  assign req_ready = w_accept ? w_onehot : '0;

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the expiry cycle still counts as success.
        if (tx_done) begin
          w_next = S_IDLE;
        end else if (r_wdog == WD_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_grant_id <= '0;
      r_last_gnt <= LAST_INIT;
      r_wdog     <= '0;
    end else begin
      r_state    <= w_next;
      r_tx_start <= w_accept;
      if (w_accept) begin
        r_tx_data  <= w_win_byte;
        r_grant_id <= w_win_idx;
        r_last_gnt <= w_win_idx;
      end
      r_wdog <= ((r_state == S_WAIT) && (w_next == S_WAIT)) ? r_wdog + 16'd1 : 16'd0;
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_start    = r_tx_start;
  assign grant_id    = r_grant_id;
  assign arb_busy    = (r_state != S_IDLE);
  assign timeout_err = w_timeout && rst_n;

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of byte requesters sharing one UART transmitter (range 2..8).
REQ-002 Parameter TIMEOUT_CYC, default 65535: maximum cycles WAIT_DONE may last before abort.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 req_valid  input  N_REQ  per-requester "byte available".
REQ-006 req_data  input  8*N_REQ  requester i byte on bits [8i+7:8i].
REQ-007 req_ready  output  N_REQ  one-hot accept strobe; byte i is taken on a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-008 tx_data  output  8  byte presented to the transmitter; registered.
REQ-009 tx_start  output  1  one-cycle launch pulse to the transmitter; registered.
REQ-010 tx_busy  input  1  transmitter is mid-frame.
REQ-011 tx_done  input  1  one-cycle pulse: frame complete.
REQ-012 grant_id  output  clog2(N_REQ)  index of the requester that owns the current or last transfer.
REQ-013 arb_busy  output  1  high in every state except IDLE.
REQ-014 timeout_err  output  1  one-cycle pulse on watchdog abort.

Function
REQ-015 FSM states: IDLE, LAUNCH, WAIT_DONE; encoding is free.
REQ-016 IDLE: if tx_busy=0 and any req_valid=1, req_ready is driven combinationally to the one-hot winner; otherwise req_ready=0.
REQ-017 Winner selection: round-robin search starting at index (last_gnt+1) mod N_REQ; the first index with req_valid=1 wins.
REQ-018 On the accept cycle: tx_data <= winner's byte; grant_id <= winner; last_gnt <= winner; next state LAUNCH.
REQ-019 LAUNCH: tx_start=1 for exactly this one cycle; next state WAIT_DONE; a tx_done seen in LAUNCH is ignored.
REQ-020 Handshake latency: tx_start rises exactly 1 cycle after the accept edge.
REQ-021 WAIT_DONE: req_ready=0; a 16-bit watchdog counter is cleared on entry and increments each cycle.
REQ-022 WAIT_DONE, tx_done=1: next state IDLE; tx_done takes priority over a simultaneous watchdog expiry.
REQ-023 WAIT_DONE, counter reaches TIMEOUT_CYC-1 without tx_done: timeout_err=1 for one cycle; next state IDLE; last_gnt still advances.
REQ-024 Back-to-back: a new accept may occur on the first IDLE cycle after tx_done; minimum grant-to-grant spacing is 3 cycles.
REQ-025 Requester behaviour: req_valid may drop without a handshake, with no side effect. tx_data and grant_id hold their values until the next accept.
REQ-026 Fairness: each requester with req_valid held high is granted within N_REQ transfers.
REQ-027 tx_busy=1 in IDLE blocks all grants; no tx_start is issued.

Reset
REQ-028 With rst_n=0 at a clock edge: state=IDLE, tx_start=0, timeout_err=0, tx_data=8'h00, grant_id=0, last_gnt=N_REQ-1 (requester 0 has first priority), watchdog=0.
REQ-029 req_ready=0 whenever rst_n=0.
REQ-030 Reset asserted mid-transfer (LAUNCH or WAIT_DONE) aborts the transfer with no timeout_err. A tx_done after reset release is ignored in IDLE.

Verification
REQ-031 Single request: req_valid=4'b0100, byte 8'hA5 -> req_ready=4'b0100 for 1 cycle, then tx_start=1 with tx_data=8'hA5 the next cycle, then grant_id=2.
REQ-032 All four requesters held valid with bytes 8'h10,8'h11,8'h12,8'h13 and tx_done returned 10 cycles after each tx_start -> tx_data sequence 8'h10,8'h11,8'h12,8'h13,8'h10 and no timeout_err.
REQ-033 Collision after grant 1: req_valid=4'b1011 -> winner 3, then 0, then 1.
REQ-034 Watchdog: TIMEOUT_CYC=20, tx_done never returned -> timeout_err pulses 20 cycles after LAUNCH exits; state IDLE; next winner = last_gnt+1.
REQ-035 tx_busy=1 in IDLE with req_valid=4'b0001 -> req_ready stays 0 and no tx_start; after tx_busy falls, the grant occurs in the same cycle.
REQ-036 rst_n=0 for 1 cycle during WAIT_DONE -> all outputs take REQ-028 values; the next grant goes to requester 0 when all requesters are valid.
